// File: rtl/mem_cmd_arbiter.sv
// mem_cmd_arbiter: merges the local (game control) and remote (interboard)
// command streams into one serialized stream towards memory handle.
// Each source feeds a small FIFO, since neither source can be stalled.
// A three-state FSM grants one command at a time and enforces a gap
// after each issued command.
// Optional build macro: MEM_ARB_REMOTE_PRIORITY_EN. When defined, the remote
// FIFO always wins a tie. When undefined, ties alternate round-robin.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for a non-empty FIFO while memory is not busy
// S_ISSUE | mem_en high for exactly one cycle, command on mem_* fields
// S_GAP   | forced idle cycles after a command, counted by gap_cnt_q
module mem_cmd_arbiter #(
    parameter int FIFO_DEPTH = 2,
    parameter int GAP        = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ctrl_en,
    input  logic       ctrl_move_dir,
    input  logic [3:0] ctrl_msg_type,
    input  logic [4:0] ctrl_block_x,
    input  logic [2:0] ctrl_block_y,
    input  logic [5:0] ctrl_card,
    input  logic [2:0] ctrl_sel_len,
    input  logic       interboard_en,
    input  logic       interboard_move_dir,
    input  logic [3:0] interboard_msg_type,
    input  logic [4:0] interboard_block_x,
    input  logic [2:0] interboard_block_y,
    input  logic [5:0] interboard_card,
    input  logic [2:0] interboard_sel_len,
    input  logic       interboard_rst,
    input  logic       mem_busy,
    output logic       mem_en,
    output logic       mem_src,
    output logic       mem_move_dir,
    output logic [3:0] mem_msg_type,
    output logic [4:0] mem_block_x,
    output logic [2:0] mem_block_y,
    output logic [5:0] mem_card,
    output logic [2:0] mem_sel_len,
    output logic       local_pending,
    output logic       remote_pending,
    output logic [1:0] overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int GW = (GAP < 2) ? 1 : $clog2(GAP);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_t;

    state_t         state_q;
    logic [GW-1:0]  gap_cnt_q;
    logic           mem_en_q;
    logic           mem_src_q;
    logic [21:0]    mem_pl_q;
    logic           last_src_q;
    logic [1:0]     overflow_q;
    logic           l_pend_q, r_pend_q;

    logic [21:0]    l_mem_q [FIFO_DEPTH];
    logic [21:0]    r_mem_q [FIFO_DEPTH];
    logic [PW-1:0]  l_wp_q, l_rp_q, r_wp_q, r_rp_q;
    logic [CW-1:0]  l_cnt_q, r_cnt_q, l_cnt_d, r_cnt_d;

    logic           clr;
    logic           l_ne, r_ne, l_full, r_full;
    logic           grant, grant_r;
    logic           l_pop, r_pop, l_push, r_push, l_drop, r_drop;
    logic [21:0]    l_pl, r_pl;

    assign l_pl = {ctrl_move_dir, ctrl_msg_type, ctrl_block_x,
                   ctrl_block_y, ctrl_card, ctrl_sel_len};
    assign r_pl = {interboard_move_dir, interboard_msg_type, interboard_block_x,
                   interboard_block_y, interboard_card, interboard_sel_len};

    // Grant decision, FIFO push/pop qualification and next occupancy.
    always_comb begin
        clr    = rst | interboard_rst;
        l_ne   = (l_cnt_q != '0);
        r_ne   = (r_cnt_q != '0);
        l_full = (l_cnt_q == CW'(FIFO_DEPTH));
        r_full = (r_cnt_q == CW'(FIFO_DEPTH));
        grant  = (state_q == S_IDLE) && !mem_busy && (l_ne || r_ne);
`ifdef MEM_ARB_REMOTE_PRIORITY_EN
        grant_r = r_ne;
`else
        grant_r = r_ne && (!l_ne || !last_src_q);
`endif
        l_pop   = grant && !grant_r;
        r_pop   = grant && grant_r;
        // A full FIFO still accepts a push when its head leaves in the same cycle.
        l_push  = ctrl_en && (!l_full || l_pop);
        r_push  = interboard_en && (!r_full || r_pop);
        l_drop  = ctrl_en && l_full && !l_pop;
        r_drop  = interboard_en && r_full && !r_pop;
        l_cnt_d = l_cnt_q + CW'(l_push) - CW'(l_pop);
        r_cnt_d = r_cnt_q + CW'(r_push) - CW'(r_pop);
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (!clr && l_push) l_mem_q[l_wp_q] <= l_pl;
        if (!clr && r_push) r_mem_q[r_wp_q] <= r_pl;
    end

    // FIFO pointers, occupancy, pending flags and sticky overflow.
    always_ff @(posedge clk) begin
        if (clr) begin
            l_wp_q     <= '0;
            l_rp_q     <= '0;
            r_wp_q     <= '0;
            r_rp_q     <= '0;
            l_cnt_q    <= '0;
            r_cnt_q    <= '0;
            l_pend_q   <= 1'b0;
            r_pend_q   <= 1'b0;
            overflow_q <= 2'b00;
        end else begin
            if (l_push) l_wp_q <= l_wp_q + 1'b1;
            if (l_pop)  l_rp_q <= l_rp_q + 1'b1;
            if (r_push) r_wp_q <= r_wp_q + 1'b1;
            if (r_pop)  r_rp_q <= r_rp_q + 1'b1;
            l_cnt_q    <= l_cnt_d;
            r_cnt_q    <= r_cnt_d;
            l_pend_q   <= (l_cnt_d != '0);
            r_pend_q   <= (r_cnt_d != '0);
            overflow_q <= overflow_q | {r_drop, l_drop};
        end
    end

    // Issue FSM with registered command outputs.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= S_IDLE;
            gap_cnt_q  <= '0;
            mem_en_q   <= 1'b0;
            mem_src_q  <= 1'b0;
            mem_pl_q   <= '0;
            last_src_q <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    mem_en_q <= 1'b0;
                    if (grant) begin
                        state_q    <= S_ISSUE;
                        mem_en_q   <= 1'b1;
                        mem_src_q  <= grant_r;
                        last_src_q <= grant_r;
                        mem_pl_q   <= grant_r ? r_mem_q[r_rp_q] : l_mem_q[l_rp_q];
                    end
                end
                S_ISSUE: begin
                    mem_en_q <= 1'b0;
                    if (GAP == 0) begin
                        state_q <= S_IDLE;
                    end else begin
                        state_q   <= S_GAP;
                        gap_cnt_q <= GW'(GAP - 1);
                    end
                end
                S_GAP: begin
                    mem_en_q <= 1'b0;
                    if (gap_cnt_q == '0) state_q <= S_IDLE;
                    else                 gap_cnt_q <= gap_cnt_q - 1'b1;
                end
                default: begin
                    state_q  <= S_IDLE;
                    mem_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_en         = mem_en_q;
    assign mem_src        = mem_src_q;
    assign {mem_move_dir, mem_msg_type, mem_block_x,
            mem_block_y, mem_card, mem_sel_len} = mem_pl_q;
    assign local_pending  = l_pend_q;
    assign remote_pending = r_pend_q;
    assign overflow       = overflow_q;

endmodule
